// File: rtl/hamming_pkg.sv
// Shared Hamming helpers for the stream decoder and its companion encoder.
// DED_W is 1 when the SEC-DED overall parity bit is enabled with HAMMING_DED_EN.
package hamming_pkg;
`ifdef HAMMING_DED_EN
    localparam int DED_W = 1;
`else
    localparam int DED_W = 0;
`endif

    // Smallest p with 2^p >= data_w + p + 1; descending scan keeps the smallest hit
    function automatic int calc_par_w(input int data_w);
        int p;
        p = 7;
        for (int k = 7; k >= 1; k--)
            if ((1 << k) >= data_w + k + 1) p = k;
        return p;
    endfunction

    function automatic int calc_cw_w(input int data_w);
        return data_w + calc_par_w(data_w) + DED_W;
    endfunction

    function automatic bit is_pow2(input int pos);
        return (pos > 0) && ((pos & (pos - 1)) == 0);
    endfunction

    // 1-based Hamming position of data bit idx (parity positions skipped)
    function automatic int data_pos(input int idx);
        int cnt;
        int pos;
        cnt = 0;
        pos = 0;
        for (int q = 1; q < 64; q++) begin
            if (!is_pow2(q)) begin
                if (cnt == idx && pos == 0) pos = q;
                cnt++;
            end
        end
        return pos;
    endfunction
endpackage

// File: rtl/hamming_stream_decoder_if.sv
// Codeword-in / result-out valid-ready bundle plus the error counter controls.
// master drives codewords, out_ready and cnt_clr; slave is the decoder.
interface hamming_stream_decoder_if #(
    parameter int DATA_W = 7,
    parameter int CNT_W  = 16
);
    import hamming_pkg::*;
    localparam int PAR_W = calc_par_w(DATA_W);
    localparam int CW_W  = calc_cw_w(DATA_W);

    logic              in_valid;
    logic              in_ready;
    logic [CW_W-1:0]   in_cw;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [PAR_W-1:0]  out_syndrome;
    logic              out_corrected;
    logic              out_uncorrectable;
    logic              cnt_clr;
    logic [CNT_W-1:0]  corr_cnt;
    logic [CNT_W-1:0]  uncorr_cnt;

    modport master (
        output in_valid, in_cw, out_ready, cnt_clr,
        input  in_ready, out_valid, out_data, out_syndrome,
               out_corrected, out_uncorrectable, corr_cnt, uncorr_cnt
    );

    modport slave (
        input  in_valid, in_cw, out_ready, cnt_clr,
        output in_ready, out_valid, out_data, out_syndrome,
               out_corrected, out_uncorrectable, corr_cnt, uncorr_cnt
    );
endinterface

// File: rtl/hamming_syndrome.sv
// Combinational Hamming syndrome: XOR of the positions of all set bits.
module hamming_syndrome
    import hamming_pkg::*;
#(
    parameter  int DATA_W = 7,
    localparam int PAR_W  = calc_par_w(DATA_W),
    localparam int HAM_W  = DATA_W + PAR_W
) (
    input  logic [HAM_W-1:0] i_cw,
    output logic [PAR_W-1:0] o_syndrome
);
    always_comb begin
        o_syndrome = '0;
        for (int i = 0; i < HAM_W; i++)
            if (i_cw[i]) o_syndrome = o_syndrome ^ PAR_W'(i + 1);
    end
endmodule

// File: rtl/hamming_stream_decoder.sv
// Two-stage Hamming SEC decoder (SEC-DED with HAMMING_DED_EN) with saturating error counters.
// Latency 2 cycles; one global enable stalls both stages when the output is held, bubbles kept.
module hamming_stream_decoder
    import hamming_pkg::*;
#(
    parameter int DATA_W = 7,
    parameter int CNT_W  = 16
) (
    input logic clk,
    input logic rst,
    hamming_stream_decoder_if.slave bus
);
    localparam int PAR_W = calc_par_w(DATA_W);
    localparam int HAM_W = DATA_W + PAR_W;
    localparam int CW_W  = calc_cw_w(DATA_W);
    localparam logic [PAR_W-1:0] MAX_POS = PAR_W'(HAM_W);

    logic              w_en;
    logic              w_hs;
    logic [PAR_W-1:0]  w_syndrome;
    logic              w_in_range;
    logic              w_fix;
    logic              w_uncorr;
    logic [HAM_W-1:0]  w_flip;
    logic [HAM_W-1:0]  w_fixed;
    logic [DATA_W-1:0] w_data;
    logic              w_unused;

    logic              r_s1_vld;
    logic [CW_W-1:0]   r_s1_cw;
    logic [PAR_W-1:0]  r_s1_syn;
    logic              r_out_vld;
    logic [DATA_W-1:0] r_out_data;
    logic [PAR_W-1:0]  r_out_syn;
    logic              r_corr;
    logic              r_uncorr;
    logic [CNT_W-1:0]  r_corr_cnt;
    logic [CNT_W-1:0]  r_uncorr_cnt;

    assign w_en         = !r_out_vld || bus.out_ready;
    assign w_hs         = r_out_vld && bus.out_ready;
    assign bus.in_ready = w_en;

    hamming_syndrome #(.DATA_W(DATA_W)) u_syndrome (
        .i_cw       (bus.in_cw[HAM_W-1:0]),
        .o_syndrome (w_syndrome)
    );

    assign w_in_range = (r_s1_syn != '0) && (r_s1_syn <= MAX_POS);

`ifdef HAMMING_DED_EN
    logic w_par_err;
    assign w_par_err = ^r_s1_cw;

    // Zero syndrome with odd parity means only the overall parity bit flipped
    always_comb begin
        w_fix    = 1'b0;
        w_uncorr = 1'b0;
        if (r_s1_syn == '0)              w_fix    = w_par_err;
        else if (w_par_err && w_in_range) w_fix    = 1'b1;
        else                              w_uncorr = 1'b1;
    end
`else
    always_comb begin
        w_fix    = 1'b0;
        w_uncorr = 1'b0;
        if (r_s1_syn != '0) begin
            if (w_in_range) w_fix    = 1'b1;
            else            w_uncorr = 1'b1;
        end
    end
`endif

    always_comb begin
        w_flip = '0;
        for (int i = 0; i < HAM_W; i++)
            w_flip[i] = w_fix && (r_s1_syn == PAR_W'(i + 1));
    end

    assign w_fixed = r_s1_cw[HAM_W-1:0] ^ w_flip;

    for (genvar j = 0; j < DATA_W; j++) begin : g_data
        assign w_data[j] = w_fixed[data_pos(j) - 1];
    end

    // Parity positions carry no data once the syndrome has been taken
    assign w_unused = ^w_fixed;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_vld   <= 1'b0;
            r_s1_cw    <= '0;
            r_s1_syn   <= '0;
            r_out_vld  <= 1'b0;
            r_out_data <= '0;
            r_out_syn  <= '0;
            r_corr     <= 1'b0;
            r_uncorr   <= 1'b0;
        end else if (w_en) begin
            r_s1_vld  <= bus.in_valid;
            r_out_vld <= r_s1_vld;
            if (bus.in_valid) begin
                r_s1_cw  <= bus.in_cw;
                r_s1_syn <= w_syndrome;
            end
            if (r_s1_vld) begin
                r_out_data <= w_data;
                r_out_syn  <= r_s1_syn;
                r_corr     <= w_fix;
                r_uncorr   <= w_uncorr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.cnt_clr) begin
            r_corr_cnt   <= '0;
            r_uncorr_cnt <= '0;
        end else begin
            if (w_hs && r_corr && !(&r_corr_cnt))
                r_corr_cnt <= r_corr_cnt + CNT_W'(1);
            if (w_hs && r_uncorr && !(&r_uncorr_cnt))
                r_uncorr_cnt <= r_uncorr_cnt + CNT_W'(1);
        end
    end

    assign bus.out_valid         = r_out_vld;
    assign bus.out_data          = r_out_data;
    assign bus.out_syndrome      = r_out_syn;
    assign bus.out_corrected     = r_corr;
    assign bus.out_uncorrectable = r_uncorr;
    assign bus.corr_cnt          = r_corr_cnt;
    assign bus.uncorr_cnt        = r_uncorr_cnt;
endmodule

// File: tb/tb_hamming_stream_decoder.sv
// Directed bench for hamming_stream_decoder (DATA_W=7, CNT_W=2), SEC or SEC-DED build.
module tb_hamming_stream_decoder;
    import hamming_pkg::*;

    localparam int DATA_W = 7;
    localparam int CNT_W  = 2;
    localparam int CW_W   = calc_cw_w(DATA_W);

    typedef struct {
        logic [CW_W-1:0] cw;
        logic [6:0]      data;
        logic [3:0]      syn;
        logic            corr;
        logic            uncorr;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    hamming_stream_decoder_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    hamming_stream_decoder #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic [11:0] cw, input logic [6:0] d,
                                input logic [3:0] s, input logic c, input logic u);
        vec_t v;
        v.cw     = cw[CW_W-1:0];
        v.data   = d;
        v.syn    = s;
        v.corr   = c;
        v.uncorr = u;
        return v;
    endfunction

    task automatic send(input logic [11:0] cw);
        logic [11:0] c;
        c            = cw;
        bus.in_valid = 1'b1;
        bus.in_cw    = c[CW_W-1:0];
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t        vecs[9];
        logic [11:0] sw_cw[4];
        logic [6:0]  sw_data[4];
        logic [11:0] cw_corr;
        logic [11:0] cw_uncorr;
        int          sent;
        int          recv;

`ifdef HAMMING_DED_EN
        vecs[0] = mk(12'h000, 7'h00, 4'd0,  1'b0, 1'b0);
        vecs[1] = mk(12'hFFF, 7'h7F, 4'd0,  1'b0, 1'b0);
        vecs[2] = mk(12'hFFE, 7'h7F, 4'd1,  1'b1, 1'b0);
        vecs[3] = mk(12'h003, 7'h00, 4'd3,  1'b0, 1'b1);
        vecs[4] = mk(12'h800, 7'h00, 4'd0,  1'b1, 1'b0);
        vecs[5] = mk(12'h400, 7'h00, 4'd11, 1'b1, 1'b0);
        vecs[6] = mk(12'h408, 7'h40, 4'd15, 1'b0, 1'b1);
        vecs[7] = mk(12'h807, 7'h01, 4'd0,  1'b0, 1'b0);
        vecs[8] = mk(12'h803, 7'h01, 4'd3,  1'b1, 1'b0);
        sw_cw   = '{12'h000, 12'hFFF, 12'h807, 12'h819};
        cw_corr   = 12'hFFE;
        cw_uncorr = 12'h003;
`else
        vecs[0] = mk(12'h000, 7'h00, 4'd0,  1'b0, 1'b0);
        vecs[1] = mk(12'h7FF, 7'h7F, 4'd0,  1'b0, 1'b0);
        vecs[2] = mk(12'h7FE, 7'h7F, 4'd1,  1'b1, 1'b0);
        vecs[3] = mk(12'h088, 7'h00, 4'd12, 1'b0, 1'b1);
        vecs[4] = mk(12'h7EF, 7'h7F, 4'd5,  1'b1, 1'b0);
        vecs[5] = mk(12'h400, 7'h00, 4'd11, 1'b1, 1'b0);
        vecs[6] = mk(12'h408, 7'h40, 4'd15, 1'b0, 1'b1);
        vecs[7] = mk(12'h007, 7'h01, 4'd0,  1'b0, 1'b0);
        vecs[8] = mk(12'h003, 7'h01, 4'd3,  1'b1, 1'b0);
        sw_cw   = '{12'h000, 12'h7FF, 12'h007, 12'h019};
        cw_corr   = 12'h7FE;
        cw_uncorr = 12'h088;
`endif
        sw_data = '{7'h00, 7'h7F, 7'h01, 7'h02};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_cw     = '0;
        bus.out_ready = 1'b0;
        bus.cnt_clr   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset out_valid",     32'(bus.out_valid), 32'd0);
        chk("reset in_ready",      32'(bus.in_ready), 32'd1);
        chk("reset out_data",      32'(bus.out_data), 32'd0);
        chk("reset syndrome",      32'(bus.out_syndrome), 32'd0);
        chk("reset corrected",     32'(bus.out_corrected), 32'd0);
        chk("reset uncorrectable", 32'(bus.out_uncorrectable), 32'd0);
        chk("reset corr_cnt",      32'(bus.corr_cnt), 32'd0);
        chk("reset uncorr_cnt",    32'(bus.uncorr_cnt), 32'd0);

        bus.out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            send(12'(vecs[i].cw));
            chk($sformatf("vec%0d out_valid", i), 32'(bus.out_valid), 32'd1);
            chk($sformatf("vec%0d data", i),      32'(bus.out_data), 32'(vecs[i].data));
            chk($sformatf("vec%0d syndrome", i),  32'(bus.out_syndrome), 32'(vecs[i].syn));
            chk($sformatf("vec%0d corrected", i), 32'(bus.out_corrected), 32'(vecs[i].corr));
            chk($sformatf("vec%0d uncorrectable", i), 32'(bus.out_uncorrectable), 32'(vecs[i].uncorr));
            chk($sformatf("vec%0d flags exclusive", i),
                32'(bus.out_corrected & bus.out_uncorrectable), 32'd0);
        end

        // Counters: clear, count, saturate, then clear racing an increment
        bus.cnt_clr = 1'b1;
        @(posedge clk); #1;
        bus.cnt_clr = 1'b0;
        chk("clr corr_cnt",   32'(bus.corr_cnt), 32'd0);
        chk("clr uncorr_cnt", 32'(bus.uncorr_cnt), 32'd0);
        send(cw_corr);
        @(posedge clk); #1;
        chk("corr_cnt after 1", 32'(bus.corr_cnt), 32'd1);
        send(cw_uncorr);
        @(posedge clk); #1;
        chk("uncorr_cnt after 1", 32'(bus.uncorr_cnt), 32'd1);
        chk("corr_cnt unchanged", 32'(bus.corr_cnt), 32'd1);
        for (int k = 2; k <= 5; k++) begin
            send(cw_corr);
            @(posedge clk); #1;
            chk($sformatf("corr_cnt after %0d", k), 32'(bus.corr_cnt), (k > 3) ? 32'd3 : 32'(k));
        end
        send(cw_corr);
        bus.cnt_clr = 1'b1;
        @(posedge clk); #1;
        bus.cnt_clr = 1'b0;
        chk("clr beats increment corr_cnt", 32'(bus.corr_cnt), 32'd0);
        chk("clr beats increment uncorr_cnt", 32'(bus.uncorr_cnt), 32'd0);

        // Back-to-back stream with a 3-cycle consumer stall
        sent = 0;
        recv = 0;
        for (int c = 0; c < 20; c++) begin
            bus.out_ready = !(c >= 2 && c <= 4);
            bus.in_valid  = (sent < 4);
            bus.in_cw     = (sent < 4) ? sw_cw[sent][CW_W-1:0] : '0;
            #1;
            if (bus.out_valid) begin
                if (recv < 4)
                    chk($sformatf("stream c%0d word %0d", c, recv), 32'(bus.out_data), 32'(sw_data[recv]));
                else
                    chk($sformatf("stream c%0d extra word", c), 32'(bus.out_valid), 32'd0);
                if (bus.out_ready) recv++;
            end
            if (!bus.out_ready)
                chk($sformatf("stream c%0d in_ready stalled", c), 32'(bus.in_ready), 32'd0);
            if (bus.in_valid && bus.in_ready) sent++;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        chk("stream words received", 32'(recv), 32'd4);

        // Reset with two words in flight
        bus.in_valid = 1'b1;
        bus.in_cw    = sw_cw[1][CW_W-1:0];
        @(posedge clk); #1;
        bus.in_cw    = sw_cw[2][CW_W-1:0];
        @(posedge clk); #1;
        chk("pre-reset out_valid", 32'(bus.out_valid), 32'd1);
        bus.in_valid = 1'b0;
        rst          = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid-stream reset out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid-stream reset out_data",  32'(bus.out_data), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk($sformatf("post-reset idle %0d", k), 32'(bus.out_valid), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
